// File: rtl/apim_input_sequencer_pkg.sv
// Shared types and constants for the APIM input sequencer.
// Slice geometry helpers, FSM states, and macro idle controls.
package apim_input_sequencer_pkg;

  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int NS          = 8 / 4;
  localparam int SLICE_IDX_W = clog2_min1(NS);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam logic CS_IDLE    = 1'b0;
  localparam logic WEB_IDLE   = 1'b1;
  localparam logic CIMEB_IDLE = 1'b1;

endpackage

// File: rtl/apim_input_sequencer_slice_mux.sv
// Picks bit-slice `sel` out of every lane of a packed vector.
// Pure combinational; shared with the weight-loading path.
module apim_slice_mux #(
  parameter int IN_PRECISION = 8,
  parameter int SLICE_BITS   = 4,
  parameter int PARALLELISM  = 16,
  parameter int SEL_W        = 1
) (
  input  logic [IN_PRECISION*PARALLELISM-1:0] data,
  input  logic [SEL_W-1:0]                    sel,
  output logic [SLICE_BITS*PARALLELISM-1:0]   slice
);

  // Gather slice `sel` of each lane into the matching output lane
  always_comb begin
    slice = '0;
    for (int k = 0; k < PARALLELISM; k++) begin
      slice[k*SLICE_BITS +: SLICE_BITS] =
        data[k*IN_PRECISION + int'(sel)*SLICE_BITS +: SLICE_BITS];
    end
  end

endmodule

// File: rtl/apim_input_sequencer.sv
// Feeds bit-sliced activation vectors into the GeMM CIM macro.
// Two-entry buffer (PEND, WORK); slices issued LSB first.
module apim_input_sequencer
  import apim_input_sequencer_pkg::*;
#(
  parameter int IN_PRECISION = 8,
  parameter int SLICE_BITS   = 4,
  parameter int PARALLELISM  = 16,
  parameter int ADDR_WIDTH   = 14,
  parameter int CIM_LATENCY  = 2,
  localparam int IDX_W =
    clog2_min1(IN_PRECISION / SLICE_BITS)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [IN_PRECISION*PARALLELISM-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0]               in_addr,
  output logic                                cim_cs,
  output logic                                cim_web,
  output logic                                cim_cimeb,
  output logic [ADDR_WIDTH-1:0]               cim_addr,
  output logic [SLICE_BITS*PARALLELISM-1:0]   cim_in,
  output logic                                slice_valid,
  output logic [IDX_W-1:0]                    slice_idx,
  output logic                                slice_last,
  output logic                                busy
);

  localparam int NUM_SLICES = IN_PRECISION / SLICE_BITS;
  localparam int HOLD_W     = clog2_min1(CIM_LATENCY);
  localparam int DW         = IN_PRECISION * PARALLELISM;
  localparam int CW         = SLICE_BITS * PARALLELISM;

  localparam logic [IDX_W-1:0]  LAST_S =
    IDX_W'(NUM_SLICES - 1);
  localparam logic [HOLD_W-1:0] LAST_H =
    HOLD_W'(CIM_LATENCY - 1);

  if (IN_PRECISION % SLICE_BITS != 0) begin : g_bad_slice
    $error("IN_PRECISION must be a multiple of SLICE_BITS");
  end
  if (CIM_LATENCY < 1) begin : g_bad_lat
    $error("CIM_LATENCY must be at least 1");
  end

  state_t                  state;
  logic                    pend_full;
  logic [DW-1:0]           pend_data;
  logic [ADDR_WIDTH-1:0]   pend_addr;
  logic [DW-1:0]           work_data;
  logic [ADDR_WIDTH-1:0]   work_addr;
  logic [IDX_W-1:0]        s;
  logic [HOLD_W-1:0]       h;
  logic [CW-1:0]           slice_now;

  logic hold_done;
  logic slice_done;
  logic pend_move;
  logic take;

  assign hold_done  = (h == LAST_H);
  assign slice_done = hold_done && (s == LAST_S);

  // PEND empties into WORK whenever WORK is free or finishing,
  // so a new vector may land in PEND on that same edge.
  assign pend_move  = pend_full &&
    ((state == IDLE) || slice_done);
  assign in_ready   = !pend_full || pend_move;
  assign take       = in_valid && in_ready;

  apim_slice_mux #(
    .IN_PRECISION (IN_PRECISION),
    .SLICE_BITS   (SLICE_BITS),
    .PARALLELISM  (PARALLELISM),
    .SEL_W        (IDX_W)
  ) u_mux (
    .data  (work_data),
    .sel   (s),
    .slice (slice_now)
  );

  // Pending register: capture on handshake, free on move to WORK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_full <= 1'b0;
      pend_data <= '0;
      pend_addr <= '0;
    end else if (take) begin
      pend_full <= 1'b1;
      pend_data <= in_data;
      pend_addr <= in_addr;
    end else if (pend_move) begin
      pend_full <= 1'b0;
    end
  end

  // Slice/hold sequencing FSM owning the WORK register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      work_data <= '0;
      work_addr <= '0;
      s         <= '0;
      h         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pend_full) begin
            work_data <= pend_data;
            work_addr <= pend_addr;
            s         <= '0;
            h         <= '0;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!hold_done) begin
            h <= h + 1'b1;
          end else if (s != LAST_S) begin
            s <= s + 1'b1;
            h <= '0;
          end else if (pend_full) begin
            work_data <= pend_data;
            work_addr <= pend_addr;
            s         <= '0;
            h         <= '0;
          end else begin
            work_data <= '0;
            work_addr <= '0;
            s         <= '0;
            h         <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered macro controls and slice tags, one cycle behind FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cim_cs      <= CS_IDLE;
      cim_web     <= WEB_IDLE;
      cim_cimeb   <= CIMEB_IDLE;
      cim_addr    <= '0;
      cim_in      <= '0;
      slice_valid <= 1'b0;
      slice_idx   <= '0;
      slice_last  <= 1'b0;
      busy        <= 1'b0;
    end else if (state == ISSUE) begin
      cim_cs      <= 1'b1;
      cim_web     <= 1'b1;
      cim_cimeb   <= 1'b0;
      cim_addr    <= work_addr;
      cim_in      <= slice_now;
      slice_valid <= hold_done;
      slice_idx   <= s;
      slice_last  <= slice_done;
      busy        <= 1'b1;
    end else begin
      cim_cs      <= CS_IDLE;
      cim_web     <= WEB_IDLE;
      cim_cimeb   <= CIMEB_IDLE;
      cim_addr    <= '0;
      cim_in      <= '0;
      slice_valid <= 1'b0;
      slice_idx   <= '0;
      slice_last  <= 1'b0;
      busy        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_apim_input_sequencer.sv
// Scoreboard bench for apim_input_sequencer.
// Directed vectors; monitor checks every slice_valid pulse.
module tb_apim_input_sequencer;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_data;
  logic [13:0]   in_addr;
  logic          cim_cs;
  logic          cim_web;
  logic          cim_cimeb;
  logic [13:0]   cim_addr;
  logic [63:0]   cim_in;
  logic          slice_valid;
  logic [0:0]    slice_idx;
  logic          slice_last;
  logic          busy;

  typedef struct packed {
    logic [63:0] d;
    logic [13:0] a;
    logic        idx;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   pulses = 0;
  int   last_cyc = -1;

  apim_input_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_addr     (in_addr),
    .cim_cs      (cim_cs),
    .cim_web     (cim_web),
    .cim_cimeb   (cim_cimeb),
    .cim_addr    (cim_addr),
    .cim_in      (cim_in),
    .slice_valid (slice_valid),
    .slice_idx   (slice_idx),
    .slice_last  (slice_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, got, exp);
    end
  endtask

  // Monitor: pop one expected slice per slice_valid pulse
  always @(negedge clk) begin
    if (rst_n === 1'b1 && slice_valid === 1'b1) begin
      exp_t e;
      pulses++;
      if (q.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        e = q.pop_front();
        chk("sb_cim_in", cim_in, e.d);
        chk("sb_addr", cim_addr, e.a);
        chk("sb_idx", slice_idx, e.idx);
        chk("sb_last", slice_last, e.last);
        chk("sb_ctrl", {cim_cs, cim_web, cim_cimeb, busy},
            4'b1101);
      end
      if (slice_last) last_cyc = cyc;
    end
  end

  task automatic send(input logic [127:0] d,
                      input logic [13:0]  a,
                      input logic [63:0]  e0,
                      input logic [63:0]  e1,
                      output int          acc);
    int n = 0;
    in_data  = d;
    in_addr  = a;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 1, 0);
    q.push_back('{d: e0, a: a, idx: 1'b0, last: 1'b0});
    q.push_back('{d: e1, a: a, idx: 1'b1, last: 1'b1});
    @(posedge clk);
    #1;
    acc      = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    repeat (3) @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_idle(input string name);
    chk({name, "_ctrl"},
        {cim_cs, cim_web, cim_cimeb, busy, slice_valid},
        5'b01100);
    chk({name, "_addr"}, cim_addr, 14'h0);
    chk({name, "_cim_in"}, cim_in, 64'h0);
    chk({name, "_tags"}, {slice_idx, slice_last}, 2'b00);
    chk({name, "_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    int a1, a2, a3, p0, n;
    logic seen_busy;
    in_valid = 1'b0;
    in_data  = '0;
    in_addr  = '0;
    rst_n    = 1'b1;
    #3 rst_n = 1'b0;
    #1 chk_idle("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single vector, all lanes 0xA5
    send({16{8'hA5}}, 14'h0123,
         {16{4'h5}}, {16{4'hA}}, a1);
    @(negedge clk);
    chk("lat_t0_busy", busy, 1'b0);
    @(negedge clk);
    chk("lat_t1_busy", busy, 1'b0);
    @(negedge clk);
    chk("s0_h0_ctrl", {cim_cs, cim_web, cim_cimeb, busy},
        4'b1101);
    chk("s0_h0_in", cim_in, {16{4'h5}});
    chk("s0_h0_addr", cim_addr, 14'h0123);
    chk("s0_h0_valid", slice_valid, 1'b0);
    @(negedge clk);
    chk("s0_h1", {slice_valid, slice_idx, slice_last},
        3'b100);
    chk("s0_h1_in", cim_in, {16{4'h5}});
    @(negedge clk);
    chk("s1_h0_in", cim_in, {16{4'hA}});
    chk("s1_h0_valid", slice_valid, 1'b0);
    @(negedge clk);
    chk("s1_h1", {slice_valid, slice_idx, slice_last},
        3'b111);
    @(negedge clk);
    chk_idle("after_a5");
    repeat (2) @(negedge clk);

    // Back-to-back vectors, no bubble between them
    p0 = pulses;
    send({16{8'h12}}, 14'h0011,
         {16{4'h2}}, {16{4'h1}}, a1);
    send({16{8'h34}}, 14'h0022,
         {16{4'h4}}, {16{4'h3}}, a2);
    chk("b2b_accept_gap", a2 - a1, 1);
    n = 0;
    while (busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_busy_cycles", n, 8);
    chk("b2b_pulses", pulses - p0, 4);
    repeat (2) @(negedge clk);

    // Backpressure: third vector waits for first to finish
    send({16{8'hC3}}, 14'h0100,
         {16{4'h3}}, {16{4'hC}}, a1);
    send({16{8'h7E}}, 14'h0200,
         {16{4'hE}}, {16{4'h7}}, a2);
    @(negedge clk);
    chk("bp_ready_low", in_ready, 1'b0);
    send({16{8'h90}}, 14'h0300,
         {16{4'h0}}, {16{4'h9}}, a3);
    @(negedge clk);
    #1;
    chk("bp_accept_edge", a3, last_cyc);
    wait_idle();

    // Lane mapping: lane 0 = 0x0F, lane 15 = 0xF0
    send({8'hF0, {14{8'h00}}, 8'h0F}, 14'h3FFF,
         64'h0000_0000_0000_000F,
         64'hF000_0000_0000_0000, a1);
    wait_idle();

    // Reset during slice 0 with PEND full
    send({16{8'h11}}, 14'h0055,
         {16{4'h1}}, {16{4'h1}}, a1);
    send({16{8'h22}}, 14'h0066,
         {16{4'h2}}, {16{4'h2}}, a2);
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk_idle("rst_mid");
    q.delete();
    p0 = pulses;
    @(negedge clk);
    rst_n = 1'b1;
    seen_busy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy !== 1'b0) seen_busy = 1'b1;
    end
    chk("rst_no_reissue", seen_busy, 1'b0);
    chk("rst_no_pulses", pulses - p0, 0);
    chk("rst_ready", in_ready, 1'b1);

    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
